pulse_width_meter: RTL

//  Downstream consumer of the glitch-filtered line (filter output sig_out).

---
 rtl/pulse_width_meter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high pulse widths (and low widths with PWM_LOW_PULSE_EN)
// and queues them in a first-word-fall-through FIFO read through a valid/ready handshake.
`default_nettype none

module pulse_width_meter #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_WIDTH  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_width,
  output logic             out_level,
  output logic             fifo_full,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PWM_LOW_PULSE_EN
  localparam int ENTRY_W = CNT_W + 1;
`else
  localparam int ENTRY_W = CNT_W;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_WIDTH);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t             state;
  logic               sig_d;
  logic [CNT_W-1:0]   cnt;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  logic               rise;
  logic               fall;
  logic [CNT_W-1:0]   cnt_inc;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  assign rise    = sig_in & ~sig_d;
  assign fall    = ~sig_in & sig_d;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    if (enable) begin
      if (state == HIGH && fall && cnt >= MIN_W) begin
        push_req = 1'b1;
`ifdef PWM_LOW_PULSE_EN
        push_data = {1'b1, cnt};
`else
        push_data = cnt;
`endif
      end
`ifdef PWM_LOW_PULSE_EN
      else if (state == LOW && rise && cnt >= MIN_W) begin
        push_req  = 1'b1;
        push_data = {1'b0, cnt};
      end
`endif
    end
  end

  // A full FIFO still takes a result when the head leaves in the same cycle.
  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (~fifo_full | pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ARM;
      cnt   <= '0;
      sig_d <= 1'b1;
    end else begin
      sig_d <= sig_in;
      if (!enable) begin
        state <= ARM;
        cnt   <= '0;
      end else begin
        case (state)
          ARM: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end
          end
          HIGH: begin
            if (fall) begin
              state <= LOW;
              cnt   <= CNT_ONE;
            end else if (sig_in) begin
              cnt <= cnt_inc;
            end
          end
          LOW: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end
`ifdef PWM_LOW_PULSE_EN
            else if (!sig_in) begin
              cnt <= cnt_inc;
            end
`endif
          end
          default: begin
            state <= ARM;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign fifo_full = (count == FULL_CNT);
  assign head      = mem[rd_ptr];
  assign out_width = out_valid ? head[CNT_W-1:0] : '0;
`ifdef PWM_LOW_PULSE_EN
  assign out_level = out_valid & head[CNT_W];
`else
  assign out_level = out_valid;
`endif

endmodule

`default_nettype wire
